snn_image_loader: RTL and testbench

- Front-end stage directly upstream of snn_core.
- Receives a 784-pixel, 1-bit-per-pixel image as a stream of UART bytes and unpacks each byte into single-bit writes to the input-unit RAM.
- When the image is complete, pulses strt to snn_core, waits for done, then hands the classified digit to the UART transmitter.
- Returns to idle for the next image.

---
 rtl/snn_image_loader_if.sv | 34 +++
 rtl/snn_image_loader.sv | 159 +++++++++++++++
 tb/tb_snn_image_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/snn_image_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : snn_image_loader_if
// Purpose  : UART-RX, input-RAM, snn_core and UART-TX signals of the loader.
// Revision : 1.0  initial release
// ============================================================================
interface snn_image_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_data;
    logic              strt;
    logic              done;
    logic [3:0]        digit;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              busy;
    logic              ovf;

    // master: the loader itself; slave: the surrounding system
    modport master (
        input  rx_rdy, rx_data, done, digit,
        output ram_we, ram_addr, ram_data, strt, tx_start, tx_data, busy, ovf
    );

    modport slave (
        output rx_rdy, rx_data, done, digit,
        input  ram_we, ram_addr, ram_data, strt, tx_start, tx_data, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/snn_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : snn_image_loader
// Purpose  : Unpacks UART bytes into 1-bit input-RAM writes, kicks snn_core
//            and forwards the classified digit to the UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
module snn_image_loader #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input wire                 clk,
    input wire                 rst_n,
    snn_image_loader_if.master bus
);
    localparam int NUM_BYTES = NUM_BITS / 8;
    localparam int c_CNT_W   = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UNPACK    = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_TX        = 3'd4
    } state_t;

    state_t             r_state;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_idx;
    logic [c_CNT_W-1:0] r_byte_cnt;
    logic               r_pend_valid;
    logic [7:0]         r_pend_data;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_ram_data;
    logic               r_strt;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_busy;
    logic               r_ovf;

    logic [2:0]         w_idx_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_load_cnt;
    logic               w_last_bit;
    logic               w_img_end;
    logic               w_load;
    logic [7:0]         w_load_byte;

    always_comb begin
        w_idx_nxt   = r_bit_idx + 3'd1;
        w_cnt_nxt   = r_byte_cnt + c_CNT_W'(1);
        w_last_bit  = (r_state == S_UNPACK) && (r_bit_idx == 3'd7);
        w_img_end   = w_last_bit && (w_cnt_nxt == c_CNT_W'(NUM_BYTES));
        // A new byte starts from IDLE or seamlessly after bit 7 of a non-final byte
        w_load      = (r_pend_valid || bus.rx_rdy) &&
                      ((r_state == S_IDLE) || (w_last_bit && !w_img_end));
        w_load_byte = r_pend_valid ? r_pend_data : bus.rx_data;
        w_load_cnt  = (r_state == S_IDLE) ? r_byte_cnt : w_cnt_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_byte_cnt <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= 1'b0;
            r_strt     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_ram_we   <= 1'b0;
            r_strt     <= 1'b0;
            r_tx_start <= 1'b0;
            if (w_load) begin
                r_state    <= S_UNPACK;
                r_busy     <= 1'b1;
                r_shift    <= w_load_byte;
                r_bit_idx  <= 3'd0;
                r_byte_cnt <= w_load_cnt;
                r_ram_we   <= 1'b1;
                r_ram_data <= w_load_byte[0];
                r_ram_addr <= ADDR_W'({w_load_cnt, 3'b000});
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_UNPACK: begin
                        if (!w_last_bit) begin
                            r_bit_idx  <= w_idx_nxt;
                            r_ram_we   <= 1'b1;
                            r_ram_data <= r_shift[w_idx_nxt];
                            r_ram_addr <= r_ram_addr + ADDR_W'(1);
                        end else if (w_img_end) begin
                            r_byte_cnt <= '0;
                            r_strt     <= 1'b1;
                            r_state    <= S_START;
                        end else begin
                            r_byte_cnt <= w_cnt_nxt;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                    S_START: r_state <= S_WAIT_DONE;
                    S_WAIT_DONE: begin
                        if (bus.done) begin
                            r_tx_data  <= {4'b0000, bus.digit};
                            r_tx_start <= 1'b1;
                            r_state    <= S_TX;
                        end
                    end
                    S_TX: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // One-byte skid buffer; a byte that finds it full, or arrives while the
    // core owns the image, is lost and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= 8'h00;
            r_ovf        <= 1'b0;
        end else if (w_load) begin
            r_pend_valid <= r_pend_valid && bus.rx_rdy;
            if (bus.rx_rdy) begin
                r_pend_data <= bus.rx_data;
            end
        end else if (bus.rx_rdy) begin
            if ((r_state == S_START) || (r_state == S_WAIT_DONE) || r_pend_valid) begin
                r_ovf <= 1'b1;
            end else begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= bus.rx_data;
            end
        end
    end

    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_data = r_ram_data;
    assign bus.strt     = r_strt;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = r_busy;
    assign bus.ovf      = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_snn_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_image_loader
// Purpose  : Randomized self-checking bench for snn_image_loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_snn_image_loader;
    localparam int     NUM_BITS  = 784;
    localparam int     ADDR_W    = 10;
    localparam int     NUM_BYTES = NUM_BITS / 8;
    localparam longint INF       = 64'sh3FFF_FFFF_FFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    snn_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

    snn_image_loader #(
        .NUM_BITS (NUM_BITS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint cyc;
        int     addr;
        bit     data;
    } wr_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    wr_t        exp_q[$];
    longint     last_start, last_end, strt_cyc, tx_cyc, ovf_from;
    int         img_bytes;
    bit         img_done;
    logic [7:0] pend_tx, cur_tx;
    bit         mon_en     = 1'b0;
    int         strt_seen  = 0;
    int         strt_model = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: each accepted byte owns 8 consecutive write cycles starting
    // one cycle after arrival or right after the previous byte; at most one
    // accepted byte may be waiting for its turn.
    task automatic model_reset();
        exp_q.delete();
        last_start = -100;
        last_end   = -100;
        strt_cyc   = INF;
        tx_cyc     = INF;
        ovf_from   = INF;
        img_bytes  = 0;
        img_done   = 1'b0;
        pend_tx    = 8'h00;
        cur_tx     = 8'h00;
    endtask

    task automatic model_rx(input logic [7:0] b, input longint t);
        longint s;
        if (img_done || (last_start > t + 1)) begin
            if (ovf_from == INF) ovf_from = t + 1;
            return;
        end
        s = (last_end + 1 > t + 1) ? last_end + 1 : t + 1;
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back('{cyc: s + j, addr: img_bytes * 8 + j, data: b[j]});
        end
        last_start = s;
        last_end   = s + 7;
        img_bytes++;
        if (img_bytes == NUM_BYTES) begin
            img_done  = 1'b1;
            img_bytes = 0;
            strt_cyc  = last_end + 1;
            tx_cyc    = INF;
            strt_model++;
        end
    endtask

    always @(negedge clk) begin : monitor
        bit exp_we;
        if (mon_en) begin
            if (cyc == tx_cyc) cur_tx = pend_tx;
            exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check_eq("ram_we", 32'(bus.ram_we), 32'(exp_we));
            if (exp_we) begin
                check_eq("ram_addr", 32'(bus.ram_addr), 32'(exp_q[0].addr));
                check_eq("ram_data", 32'(bus.ram_data), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
            check_eq("strt", 32'(bus.strt), 32'(cyc == strt_cyc));
            check_eq("tx_start", 32'(bus.tx_start), 32'(cyc == tx_cyc));
            check_eq("tx_data", 32'(bus.tx_data), 32'(cur_tx));
            check_eq("busy", 32'(bus.busy), 32'(exp_we || (cyc >= strt_cyc && cyc <= tx_cyc)));
            check_eq("ovf", 32'(bus.ovf), 32'(cyc >= ovf_from));
            if (bus.strt === 1'b1) strt_seen++;
        end
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        model_rx(b, cyc);
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'($urandom);
    endtask

    // mode 0: all 8'hA5; mode 1: random with byte index 3 = 8'h01; mode 2: random
    task automatic run_image(input int mode, input int idle_lo, input int idle_hi, input int stop_at);
        logic [7:0] b;
        for (int n = 0; n < 400 && !img_done && !(stop_at > 0 && img_bytes >= stop_at); n++) begin
            b = (mode == 0) ? 8'hA5 : 8'($urandom);
            if (mode == 1 && img_bytes == 3) b = 8'h01;
            send_byte(b);
            idle(int'($urandom_range(idle_hi, idle_lo)));
        end
    endtask

    task automatic send_done(input logic [3:0] d, input int extra);
        while (cyc < strt_cyc + extra && cyc < 200000) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.done  = 1'b1;
        bus.digit = d;
        tx_cyc    = cyc + 1;
        pend_tx   = {4'b0000, d};
        img_done  = 1'b0;
        @(posedge clk);
        #1;
        bus.done  = 1'b0;
        bus.digit = 4'($urandom);
        idle(3);
        check_eq("strt_count", 32'(strt_seen), 32'(strt_model));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;
        bus.done    = 1'b0;
        bus.digit   = 4'h0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check_eq("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check_eq("rst_ram_data", 32'(bus.ram_data), 32'd0);
        check_eq("rst_strt", 32'(bus.strt), 32'd0);
        check_eq("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Image of 8'hA5 with 20-cycle spacing, digit 7
        run_image(0, 18, 18, 0);
        send_done(4'd7, 4);

        // Random image, spacing 8..22 (includes rx on the final unpack cycle)
        run_image(1, 6, 20, 0);
        send_done(4'($urandom), int'($urandom_range(10, 0)));

        // Three pulses inside one unpack, then a byte lost while waiting for done
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        idle(8);
        run_image(2, 6, 20, 0);
        while (cyc < strt_cyc + 2 && cyc < 200000) begin
            @(posedge clk);
            #1;
        end
        send_byte(8'($urandom));
        send_done(4'($urandom), 3);

        // Dense random traffic with drops; ovf stays set
        run_image(2, 0, 10, 0);
        send_done(4'($urandom), int'($urandom_range(6, 1)));

        // Reset mid-image, then a complete fresh image
        run_image(2, 6, 14, 50);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        run_image(2, 6, 14, 0);
        send_done(4'($urandom), 2);

        idle(5);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
